cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle sequencer for the RV32I core: fetches instructions over a request/acknowledge instruction-memory port and holds each one in an instruction register that drives the `control` decoder. It uses the decoder's `rf_we`/`mem_we` to gate register-file writes and data-memory stores to exactly one commit per instruction, and advances the PC. It provides run/single-step/halt control and a retired-instruction counter for bring-up on the FPGA.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `run`  in  1  level; when 1, instructions execute back-to-back.
- `step`  in  1  one-cycle pulse; sampled only in IDLE with `run`=0; executes exactly one instruction.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; always equal to `pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  instruction register; feeds the decoder.
- `dec_rf_we`  in  1  decoder register-file write enable.
- `dec_mem_we`  in  1  decoder memory write enable.
- `rf_we`  out  1  gated register-file write strobe.
- `dmem_req`  out  1  store request; the address and data come from the datapath.
- `dmem_ack`  in  1  store accepted.
- `pc`  out  32  current PC.
- `retired`  out  1  one-cycle pulse on each instruction commit.
- `instret`  out  32  count of retired instructions.
- `halted`  out  1  illegal instruction trapped.
- `busy`  out  1  1 in any state other than IDLE and HALT.

## Operation
- The FSM is Moore-style, with registered state. States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE:
  - If `run`=1, or `step`=1 while `run`=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `imem_req`=1, held until `imem_ack`.
  - On `imem_ack`: `instr` <= `imem_rdata`; go to EXEC.
  - `imem_ack` is ignored in every other state.
- EXEC (exactly one cycle; the decoder outputs are valid from `instr`):
  - If `dec_rf_we`=1: `rf_we`=1 this cycle, then commit.
  - Else if `dec_mem_we`=1: go to MEM.
  - Else (the decoder produced no action, so the instruction is illegal or unsupported): go to HALT; `pc` stays at the trapping instruction.
- MEM:
  - `dmem_req`=1, held until `dmem_ack`.
  - On `dmem_ack`: commit.
- Commit (occurs in the EXEC or MEM cycle):
  - `pc` <= `pc`+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `retired`=1 for that cycle; `instret` += 1, wrapping to 0.
  - Next state is FETCH if `run`=1, else IDLE.
- HALT: absorbing state; `halted`=1. Only `rst_n` leaves it.
- Deasserting `run` mid-instruction: the current instruction completes; the sequencer then goes to IDLE.
- `step` pulses outside IDLE, or while `run`=1, are ignored.
- `rf_we` and `dmem_req` are never asserted in the same cycle. Each instruction produces at most one `rf_we` cycle.

## Timing
- Reset (with `rst_n`=0 at an edge):
  - state=IDLE, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instret`=0.
  - `imem_req`, `dmem_req`, `rf_we`, `retired`, `halted`, `busy` all 0.
- Reset wins over every other event, including mid-FETCH or mid-MEM. The outstanding request drops the cycle after the reset edge; a late ack is ignored.
- Start latency: `run` sampled high at edge N puts `imem_req` high in cycle N+1.
- An ack in the first FETCH cycle is legal.
- ALU instructions take a minimum of 2 cycles (FETCH, EXEC). Stores take a minimum of 3 cycles (FETCH, EXEC, MEM).
- Each additional wait cycle on `imem_ack` or `dmem_ack` adds 1 cycle.
- `pc`, `instret` and `instr` update at the commit edge and the fetch-ack edge respectively. The new values are visible the next cycle.

## Structure
- Shared `cpu_pkg` holds:
  - state encoding (localparams for IDLE, FETCH, EXEC, MEM, HALT);
  - `NOP_INSTR` = 32'h0000_0013;
  - the default `RESET_PC`.
- Single module with no sub-module. The PC incrementer and `instret` counter are inline registers.

## Test plan
- Reset then `run`=1, `imem_ack` in the first cycle, program ADDI, ADDI, XOR:
  - `retired` pulses every 2 cycles;
  - `pc` steps 0 → 4 → 8 → 12;
  - `instret`=3;
  - `rf_we` is high exactly 3 cycles.
- SW at PC 8 with `dmem_ack` delayed 3 cycles:
  - `dmem_req` high 4 cycles;
  - `rf_we` stays 0;
  - `pc` becomes 12 one cycle after the ack.
- `run`=0, three `step` pulses (one issued mid-instruction):
  - exactly 2 instructions retire;
  - the sequencer returns to IDLE;
  - `busy`=0.
- Fetch of 32'h0000_0000 at PC 16:
  - `halted`=1, `pc` stays 16, `retired` never pulses;
  - further `run`/`step` have no effect until reset.
- `rst_n` low during MEM wait, then `dmem_ack` arrives:
  - ack ignored;
  - `pc`=`RESET_PC`, `instret`=0, `instr`=32'h0000_0013.
- `RESET_PC`=32'hFFFF_FFFC, one ADDI:
  - `pc` wraps to 0;
  - `imem_addr`=0 on the next fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding and reset constants
package cpu_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    HALT  = 3'd4
  } state_t;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/exec/store sequencer with run, step and halt control
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_rf_we,
  input  logic        dec_mem_we,
  output logic        rf_we,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [31:0] pc,
  output logic        retired,
  output logic [31:0] instret,
  output logic        halted,
  output logic        busy
);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d;
  logic        commit;
  always_comb begin
    commit = (state_q == EXEC && dec_rf_we) || (state_q == MEM && dmem_ack);
    case (state_q)
      IDLE:    state_d = (run || step) ? FETCH : IDLE;
      FETCH:   state_d = imem_ack ? EXEC : FETCH;
      EXEC:    state_d = dec_rf_we ? (run ? FETCH : IDLE) : (dec_mem_we ? MEM : HALT);
      MEM:     state_d = dmem_ack ? (run ? FETCH : IDLE) : MEM;
      default: state_d = HALT;
    endcase
    pc_d      = commit ? pc_q + 32'd4 : pc_q;
    instr_d   = (state_q == FETCH && imem_ack) ? imem_rdata : instr_q;
    instret_d = commit ? instret_q + 32'd1 : instret_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end
  assign imem_req  = state_q == FETCH;
  assign imem_addr = pc_q;
  assign dmem_req  = state_q == MEM;
  assign rf_we     = state_q == EXEC && dec_rf_we;
  assign retired   = commit;
  assign halted    = state_q == HALT;
  assign busy      = state_q != IDLE && state_q != HALT;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized bench checking retire timing, counts and control against a per-instruction cycle model
module tb_cpu_sequencer;
  import cpu_pkg::*;
  logic clk = 0, rst_n = 0, run = 0, step = 0;
  logic imem_ack = 0, dmem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic imem_req, dmem_req, rf_we, retired, halted, busy, dec_rf_we, dec_mem_we;
  logic [31:0] imem_addr, instr, pc, instret;
  logic imem_req2, dmem_req2, rf_we2, retired2, halted2, busy2;
  logic [31:0] imem_addr2, instr2, pc2, instret2;
  logic [31:0] prog [32];
  int checks = 0, errors = 0, cyc = 0;
  int fetch_wait = 0, mem_wait = 0, fcnt = 0, mcnt = 0;
  int rf_cnt = 0, dm_cnt = 0, im_cnt = 0, overlap = 0;
  bit mem_manual = 0;
  int ret_cyc[$];
  logic [31:0] ret_pc[$];

  always #5 clk = ~clk;

  function automatic bit is_alu(input logic [31:0] i);
    return i[6:0] == 7'h13 || i[6:0] == 7'h33 || i[6:0] == 7'h37;
  endfunction
  function automatic bit is_store(input logic [31:0] i);
    return i[6:0] == 7'h23;
  endfunction
  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return a < 32'd128 ? prog[a[6:2]] : 32'h0;
  endfunction
  function automatic logic [31:0] rand_alu();
    logic [31:0] r;
    int s;
    r = $urandom;
    s = $urandom_range(0, 2);
    return {r[31:7], s == 0 ? 7'h13 : s == 1 ? 7'h33 : 7'h37};
  endfunction
  function automatic logic [31:0] rand_store();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], 7'h23};
  endfunction

  assign dec_rf_we  = is_alu(instr);
  assign dec_mem_we = is_store(instr);

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .dec_rf_we(dec_rf_we), .dec_mem_we(dec_mem_we), .rf_we(rf_we),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc(pc), .retired(retired),
    .instret(instret), .halted(halted), .busy(busy)
  );
  cpu_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr2), .dec_rf_we(dec_rf_we), .dec_mem_we(dec_mem_we), .rf_we(rf_we2),
    .dmem_req(dmem_req2), .dmem_ack(dmem_ack), .pc(pc2), .retired(retired2),
    .instret(instret2), .halted(halted2), .busy(busy2)
  );

  // Memory responders drive just after the edge; garbage rdata outside ack cycles.
  initial forever begin
    @(posedge clk); #1;
    if (imem_req && fcnt >= fetch_wait) begin
      imem_ack = 1; imem_rdata = fetch_word(imem_addr); fcnt = 0;
    end else begin
      imem_ack = 0; imem_rdata = $urandom; fcnt = imem_req ? fcnt + 1 : 0;
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (!mem_manual) begin
      if (dmem_req && mcnt >= mem_wait) begin
        dmem_ack = 1; mcnt = 0;
      end else begin
        dmem_ack = 0; mcnt = dmem_req ? mcnt + 1 : 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (retired) begin ret_cyc.push_back(cyc); ret_pc.push_back(pc); end
    if (rf_we) rf_cnt++;
    if (dmem_req) dm_cnt++;
    if (imem_req) im_cnt++;
    if (rf_we && dmem_req) overlap++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    tick(); rst_n = 0; run = 0; step = 0;
    tick(); rst_n = 1;
    ret_cyc.delete(); ret_pc.delete();
    rf_cnt = 0; dm_cnt = 0; im_cnt = 0; overlap = 0;
  endtask
  task automatic clear_prog();
    for (int k = 0; k < 32; k++) prog[k] = 32'h0;
  endtask

  // Runs the loaded program until it traps on the first illegal word, then checks it against the model.
  task automatic check_program(input string name, input int fw, input int mw);
    int c, e, first, stores, fetches;
    int exp_cyc[$];
    logic [31:0] exp_pc[$];
    logic [31:0] p, w;
    do_reset();
    fetch_wait = fw; mem_wait = mw;
    first = cyc + 2;
    run = 1;
    for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL %s halt_timeout: halted=%b exp 1", name, halted); end
    c = first; p = RESET_PC_DEFAULT; stores = 0; fetches = 0; w = 0;
    for (int k = 0; k < 32; k++) begin
      w = fetch_word(p); fetches++; e = c + fw + 1;
      if (is_alu(w)) begin
        exp_cyc.push_back(e); exp_pc.push_back(p); c = e + 1; p = p + 4;
      end else if (is_store(w)) begin
        stores++; exp_cyc.push_back(e + 1 + mw); exp_pc.push_back(p); c = e + mw + 2; p = p + 4;
      end else break;
    end
    checks++;
    if (ret_cyc.size() != exp_cyc.size()) begin errors++; $display("FAIL %s retire_count: got %0d exp %0d", name, ret_cyc.size(), exp_cyc.size()); end
    for (int k = 0; k < exp_cyc.size() && k < ret_cyc.size(); k++) begin
      checks++;
      if (ret_cyc[k] != exp_cyc[k] || ret_pc[k] !== exp_pc[k]) begin
        errors++; $display("FAIL %s retire[%0d]: got cyc %0d pc %h exp cyc %0d pc %h", name, k, ret_cyc[k], ret_pc[k], exp_cyc[k], exp_pc[k]);
      end
    end
    checks++;
    if (pc !== p) begin errors++; $display("FAIL %s trap_pc: got %h exp %h", name, pc, p); end
    checks++;
    if (instret !== 32'(exp_cyc.size())) begin errors++; $display("FAIL %s instret: got %0d exp %0d", name, instret, exp_cyc.size()); end
    checks++;
    if (instr !== w) begin errors++; $display("FAIL %s instr: got %h exp %h", name, instr, w); end
    checks++;
    if (rf_cnt != exp_cyc.size() - stores) begin errors++; $display("FAIL %s rf_we_cycles: got %0d exp %0d", name, rf_cnt, exp_cyc.size() - stores); end
    checks++;
    if (dm_cnt != stores * (mw + 1)) begin errors++; $display("FAIL %s dmem_req_cycles: got %0d exp %0d", name, dm_cnt, stores * (mw + 1)); end
    checks++;
    if (im_cnt != fetches * (fw + 1)) begin errors++; $display("FAIL %s imem_req_cycles: got %0d exp %0d", name, im_cnt, fetches * (fw + 1)); end
    checks++;
    if (overlap != 0 || busy !== 1'b0) begin errors++; $display("FAIL %s overlap_busy: got overlap %0d busy %b exp 0 0", name, overlap, busy); end
    tick(); run = 0;
    tick(); step = 1;
    tick(); step = 0; run = 1;
    repeat (5) tick();
    run = 0;
    tick();
    @(negedge clk);
    checks++;
    if (pc !== p || halted !== 1'b1 || ret_cyc.size() != exp_cyc.size() || im_cnt != fetches * (fw + 1))
      begin errors++; $display("FAIL %s halt_absorbing: got pc %h halted %b ret %0d exp pc %h halted 1 ret %0d", name, pc, halted, ret_cyc.size(), p, exp_cyc.size()); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (pc !== RESET_PC_DEFAULT) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, RESET_PC_DEFAULT); end
    checks++;
    if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", instr); end
    checks++;
    if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h exp 0", instret); end
    checks++;
    if ({imem_req, dmem_req, rf_we, retired, halted, busy} !== 6'b0)
      begin errors++; $display("FAIL reset_controls: got %b exp 000000", {imem_req, dmem_req, rf_we, retired, halted, busy}); end
  endtask

  task automatic test_alu_seq();
    clear_prog();
    prog[0] = 32'h0050_0093; prog[1] = 32'h0070_0113; prog[2] = 32'h0020_C1B3;
    check_program("alu_seq", 0, 0);
  endtask

  task automatic test_store_wait();
    clear_prog();
    prog[0] = 32'h0050_0093; prog[1] = 32'h0070_0113; prog[2] = 32'h0030_2023;
    check_program("store_wait", 0, 3);
  endtask

  task automatic test_random_prog();
    clear_prog();
    for (int k = 0; k < 4; k++) prog[k] = $urandom_range(0, 2) == 0 ? rand_store() : rand_alu();
    check_program("random_prog", $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_step();
    clear_prog();
    for (int k = 0; k < 4; k++) prog[k] = rand_alu();
    do_reset();
    fetch_wait = 2; mem_wait = 0;
    tick(); step = 1;
    tick(); step = 0;
    tick(); step = 1;
    tick(); step = 0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    repeat (3) tick();
    step = 1;
    tick(); step = 0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (ret_cyc.size() != 2) begin errors++; $display("FAIL step_retired: got %0d exp 2", ret_cyc.size()); end
    checks++;
    if (pc !== 32'd8 || instret !== 32'd2) begin errors++; $display("FAIL step_pc_instret: got pc %h instret %0d exp 8 2", pc, instret); end
    checks++;
    if ({busy, imem_req, halted} !== 3'b000) begin errors++; $display("FAIL step_idle: got busy/imem_req/halted %b exp 000", {busy, imem_req, halted}); end
  endtask

  task automatic test_reset_mid_mem();
    clear_prog();
    prog[0] = rand_store();
    do_reset();
    mem_manual = 1; dmem_ack = 0; fetch_wait = 0;
    run = 1;
    for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mem_reach: dmem_req=%b exp 1", dmem_req); end
    tick(); tick();
    rst_n = 0; run = 0;
    tick(); rst_n = 1; dmem_ack = 1;
    @(negedge clk);
    checks++;
    if ({dmem_req, busy, retired} !== 3'b000) begin errors++; $display("FAIL rst_mem_drop: got dmem_req/busy/retired %b exp 000", {dmem_req, busy, retired}); end
    tick(); dmem_ack = 0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || instret !== 32'h0 || instr !== 32'h0000_0013 || ret_cyc.size() != 0)
      begin errors++; $display("FAIL rst_mem_state: got pc %h instret %0d instr %h ret %0d exp 0 0 00000013 0", pc, instret, instr, ret_cyc.size()); end
    mem_manual = 0;
  endtask

  task automatic test_pc_wrap();
    clear_prog();
    prog[0] = rand_alu();
    do_reset();
    fetch_wait = 0;
    run = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_fetch: got req %b addr %h exp 1 fffffffc", imem_req2, imem_addr2); end
    @(negedge clk);
    checks++;
    if (retired2 !== 1'b1) begin errors++; $display("FAIL wrap_retire: got %b exp 1", retired2); end
    @(negedge clk);
    checks++;
    if (pc2 !== 32'h0 || imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_next_fetch: got pc %h req %b addr %h exp 0 1 0", pc2, imem_req2, imem_addr2); end
    for (int i = 0; i < 20 && !halted2; i++) @(negedge clk);
    tick(); run = 0;
    @(negedge clk);
    checks++;
    if (halted2 !== 1'b1 || pc2 !== 32'h0 || instret2 !== 32'd1) begin errors++; $display("FAIL wrap_final: got halted %b pc %h instret %0d exp 1 0 1", halted2, pc2, instret2); end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_store_wait();
    test_step();
    test_reset_mid_mem();
    test_pc_wrap();
    repeat (4) test_random_prog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
